// File: rtl/drac_pkg.sv
// ----------------------------------------------------------------------------
// drac_pkg
//   Shared constants and types for the rename-stage physical register file
//   bookkeeping.
//
//   Contents:
//     FL_NUM_PHYS_REGS / FL_NUM_ARCH_REGS : default physical/architectural
//                                          register counts
//     FL_NUM_ENTRIES                      : free-list depth (phys - arch)
//     FL_TAG_W / FL_PTR_W                 : tag and free-list pointer widths
//     phreg_t                             : physical register tag
//     fl_cnt2()                           : 2-input population count
// ----------------------------------------------------------------------------
package drac_pkg;

  localparam int FL_NUM_PHYS_REGS = 64;
  localparam int FL_NUM_ARCH_REGS = 32;
  localparam int FL_NUM_ENTRIES   = FL_NUM_PHYS_REGS - FL_NUM_ARCH_REGS;
  localparam int FL_TAG_W         = $clog2(FL_NUM_PHYS_REGS);
  localparam int FL_PTR_W         = $clog2(FL_NUM_ENTRIES);

  typedef logic [FL_TAG_W-1:0] phreg_t;

  // Number of set bits among two request/release strobes (0..2).
  function automatic logic [1:0] fl_cnt2(input logic a, input logic b);
    return {1'b0, a} + {1'b0, b};
  endfunction

endpackage

// File: rtl/ir_free_list_ptr.sv
// ----------------------------------------------------------------------------
// ir_free_list_ptr
//   Wrapping free-list pointer. Each cycle it either advances by 0, 1 or 2
//   (wrapping modulo 2**PTR_W) or is loaded with a restore value.
//
//   Ports:
//     clk_i       in   clock
//     rstn_i      in   asynchronous active-low reset (pointer -> 0)
//     inc_i       in   advance amount (0..2)
//     load_i      in   load load_val_i instead of advancing
//     load_val_i  in   restore value
//     ptr_o       out  current pointer value
// ----------------------------------------------------------------------------
module ir_free_list_ptr #(
  parameter int PTR_W = 5
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic [1:0]       inc_i,
  input  logic             load_i,
  input  logic [PTR_W-1:0] load_val_i,
  output logic [PTR_W-1:0] ptr_o
);

  logic [PTR_W-1:0] r_ptr;
  logic [PTR_W-1:0] w_ptr_next;

  // The pointer width is exactly log2 of the list depth, so plain binary
  // overflow provides the modulo wrap.
  always_comb begin
    w_ptr_next = r_ptr + PTR_W'(inc_i);
    if (load_i) begin
      w_ptr_next = load_val_i;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_ptr <= '0;
    end else begin
      r_ptr <= w_ptr_next;
    end
  end

  assign ptr_o = r_ptr;

endmodule

// File: rtl/ir_free_list.sv
// ----------------------------------------------------------------------------
// ir_free_list
//   Physical-register free list for the rename stage. Hands out up to two
//   free tags per cycle (one per instruction slot), takes back up to two
//   graduated tags per cycle, and on flush rewinds the speculative head to
//   the committed head.
//
//   Optional build macro: FREE_LIST_BYPASS_EN
//     When defined, tags released in the same cycle may be handed straight to
//     allocation when the list alone cannot cover the request.
//
//   Ports:
//     clk_i            in   clock
//     rstn_i           in   asynchronous active-low reset
//     alloc_1_i        in   slot 1 needs a destination tag
//     alloc_2_i        in   slot 2 needs a destination tag
//     tag_1_o          out  tag for slot 1
//     tag_2_o          out  tag for slot 2 (compacted when only slot 2 asks)
//     stall_o          out  not enough free tags; nothing allocated
//     release_1_i      in   return release_tag_1_i to the list
//     release_tag_1_i  in   tag freed by graduation
//     release_2_i      in   return release_tag_2_i to the list
//     release_tag_2_i  in   tag freed by graduation
//     commit_1_i       in   one allocation retired
//     commit_2_i       in   second allocation retired
//     flush_i          in   recovery: restore head/count from committed state
//     empty_o          out  no free tags
//     num_free_o       out  current free count
// ----------------------------------------------------------------------------
module ir_free_list
  import drac_pkg::*;
#(
  parameter  int NUM_PHYS_REGS = FL_NUM_PHYS_REGS,
  parameter  int NUM_ARCH_REGS = FL_NUM_ARCH_REGS,
  localparam int FL_ENTRIES    = NUM_PHYS_REGS - NUM_ARCH_REGS,
  localparam int TAG_W         = $clog2(NUM_PHYS_REGS),
  localparam int PTR_W         = $clog2(FL_ENTRIES)
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             alloc_1_i,
  input  logic             alloc_2_i,
  output logic [TAG_W-1:0] tag_1_o,
  output logic [TAG_W-1:0] tag_2_o,
  output logic             stall_o,
  input  logic             release_1_i,
  input  logic [TAG_W-1:0] release_tag_1_i,
  input  logic             release_2_i,
  input  logic [TAG_W-1:0] release_tag_2_i,
  input  logic             commit_1_i,
  input  logic             commit_2_i,
  input  logic             flush_i,
  output logic             empty_o,
  output logic [PTR_W:0]   num_free_o
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(FL_ENTRIES);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [TAG_W-1:0] r_buf [FL_ENTRIES];
  logic [PTR_W:0]   r_count;
  logic [PTR_W:0]   r_commit_count;

  logic [PTR_W-1:0] w_head;
  logic [PTR_W-1:0] w_commit_head;
  logic [PTR_W-1:0] w_tail;
  logic [PTR_W-1:0] w_head_p1;
  logic [PTR_W-1:0] w_tail_p1;
  logic [PTR_W-1:0] w_head_restore;

  // --------------------------------------------------------------------------
  // Request / release bookkeeping
  // --------------------------------------------------------------------------
  logic [1:0]       w_req;
  logic [PTR_W:0]   w_req_c;
  logic [1:0]       w_commit_n;
  logic [1:0]       w_alloc_n;
  logic [1:0]       w_byp_n;
  logic [1:0]       w_wr_n;
  logic [1:0]       w_acc_n;
  logic [1:0]       w_head_inc;
  logic [PTR_W:0]   w_room;
  logic             w_stall;
  logic             w_grant;
  logic             w_we_0;
  logic             w_we_1;

  logic [TAG_W-1:0] w_buf_t0;
  logic [TAG_W-1:0] w_buf_t1;
  logic [TAG_W-1:0] w_alloc_t0;
  logic [TAG_W-1:0] w_alloc_t1;

  // Releases compacted so the first valid one is always in position 0.
  logic             w_rl_v0;
  logic             w_rl_v1;
  logic [TAG_W-1:0] w_rl_t0;
  logic [TAG_W-1:0] w_rl_t1;

  // Releases left over for the buffer after any bypass, still compacted.
  logic             w_wr_v0;
  logic             w_wr_v1;
  logic [TAG_W-1:0] w_wr_t0;
  logic [TAG_W-1:0] w_wr_t1;

  logic [PTR_W+1:0] w_count_sum;
  logic [PTR_W+1:0] w_ccount_sum;
  logic [PTR_W:0]   w_count_next;
  logic [PTR_W:0]   w_commit_count_next;

  assign w_req      = fl_cnt2(alloc_1_i, alloc_2_i);
  assign w_req_c    = (PTR_W+1)'(w_req);
  assign w_commit_n = fl_cnt2(commit_1_i, commit_2_i);

  assign w_head_p1  = w_head + PTR_W'(1);
  assign w_tail_p1  = w_tail + PTR_W'(1);
  assign w_buf_t0   = r_buf[w_head];
  assign w_buf_t1   = r_buf[w_head_p1];

  assign w_rl_v0    = release_1_i | release_2_i;
  assign w_rl_t0    = release_1_i ? release_tag_1_i : release_tag_2_i;
  assign w_rl_v1    = release_1_i & release_2_i;
  assign w_rl_t1    = release_tag_2_i;

`ifdef FREE_LIST_BYPASS_EN
  logic [1:0]     w_rel_n;
  logic [PTR_W:0] w_deficit;

  assign w_rel_n   = fl_cnt2(release_1_i, release_2_i);
  // Same-cycle releases count toward the supply for stall purposes.
  assign w_stall   = (PTR_W+2)'(w_req) > ((PTR_W+2)'(r_count) + (PTR_W+2)'(w_rel_n));
  assign w_grant   = !w_stall && !flush_i;
  assign w_deficit = (w_req_c > r_count) ? (w_req_c - r_count) : '0;
  // Bypassed tags cover only the part of the request the list cannot.
  assign w_byp_n   = w_grant ? w_deficit[1:0] : 2'd0;
  // The k-th granted tag comes from the list while it lasts, then from the
  // compacted release stream in order.
  assign w_alloc_t0 = (r_count != '0) ? w_buf_t0 : w_rl_t0;
  assign w_alloc_t1 = (r_count > (PTR_W+1)'(1)) ? w_buf_t1 :
                      ((r_count == (PTR_W+1)'(1)) ? w_rl_t0 : w_rl_t1);
`else
  assign w_stall    = w_req_c > r_count;
  assign w_grant    = !w_stall && !flush_i;
  assign w_byp_n    = 2'd0;
  assign w_alloc_t0 = w_buf_t0;
  assign w_alloc_t1 = w_buf_t1;
`endif

  assign w_alloc_n  = w_grant ? w_req : 2'd0;
  // Head only moves past tags actually taken from the buffer.
  assign w_head_inc = w_alloc_n - w_byp_n;

  // Drop the releases consumed by bypass from the front of the stream.
  always_comb begin
    w_wr_v0 = w_rl_v0;
    w_wr_t0 = w_rl_t0;
    w_wr_v1 = w_rl_v1;
    w_wr_t1 = w_rl_t1;
    case (w_byp_n)
      2'd0: ;
      2'd1: begin
        w_wr_v0 = w_rl_v1;
        w_wr_t0 = w_rl_t1;
        w_wr_v1 = 1'b0;
      end
      default: begin
        w_wr_v0 = 1'b0;
        w_wr_v1 = 1'b0;
      end
    endcase
  end

  // Releases beyond the free space are dropped so the list never overfills.
  assign w_wr_n  = fl_cnt2(w_wr_v0, w_wr_v1);
  assign w_room  = FULL_CNT - r_count;
  assign w_acc_n = ((PTR_W+1)'(w_wr_n) > w_room) ? w_room[1:0] : w_wr_n;
  assign w_we_0  = (w_acc_n != 2'd0);
  assign w_we_1  = (w_acc_n == 2'd2);

  // --------------------------------------------------------------------------
  // Count arithmetic (one bit of headroom, then saturate at full)
  // --------------------------------------------------------------------------
  assign w_count_sum  = (PTR_W+2)'(r_count) + (PTR_W+2)'(w_acc_n)
                      + (PTR_W+2)'(w_byp_n) - (PTR_W+2)'(w_alloc_n);
  assign w_ccount_sum = (PTR_W+2)'(r_commit_count) + (PTR_W+2)'(w_acc_n)
                      + (PTR_W+2)'(w_byp_n) - (PTR_W+2)'(w_commit_n);

  assign w_commit_count_next = (w_ccount_sum > (PTR_W+2)'(FULL_CNT)) ? FULL_CNT
                                                                     : w_ccount_sum[PTR_W:0];

  always_comb begin
    w_count_next = (w_count_sum > (PTR_W+2)'(FULL_CNT)) ? FULL_CNT : w_count_sum[PTR_W:0];
    if (flush_i) begin
      // Rewind to the committed view, including this cycle's releases/commits.
      w_count_next = w_commit_count_next;
    end
  end

  // Head restore includes commits retiring in the flush cycle itself.
  assign w_head_restore = w_commit_head + PTR_W'(w_commit_n);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_count        <= FULL_CNT;
      r_commit_count <= FULL_CNT;
    end else begin
      r_count        <= w_count_next;
      r_commit_count <= w_commit_count_next;
    end
  end

  // --------------------------------------------------------------------------
  // Tag buffer: every non-architectural tag starts out free, in order.
  // Needs reset contents and two combinational reads, so it is a register file.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < FL_ENTRIES; i++) begin
        r_buf[i] <= TAG_W'(NUM_ARCH_REGS + i);
      end
    end else begin
      if (w_we_0) begin
        r_buf[w_tail] <= w_wr_t0;
      end
      if (w_we_1) begin
        r_buf[w_tail_p1] <= w_wr_t1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Pointers
  // --------------------------------------------------------------------------
  ir_free_list_ptr #(.PTR_W(PTR_W)) u_head_ptr (
    .clk_i      (clk_i),
    .rstn_i     (rstn_i),
    .inc_i      (w_head_inc),
    .load_i     (flush_i),
    .load_val_i (w_head_restore),
    .ptr_o      (w_head)
  );

  ir_free_list_ptr #(.PTR_W(PTR_W)) u_commit_head_ptr (
    .clk_i      (clk_i),
    .rstn_i     (rstn_i),
    .inc_i      (w_commit_n),
    .load_i     (1'b0),
    .load_val_i ('0),
    .ptr_o      (w_commit_head)
  );

  ir_free_list_ptr #(.PTR_W(PTR_W)) u_tail_ptr (
    .clk_i      (clk_i),
    .rstn_i     (rstn_i),
    .inc_i      (w_acc_n),
    .load_i     (1'b0),
    .load_val_i ('0),
    .ptr_o      (w_tail)
  );

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign tag_1_o    = w_alloc_t0;
  assign tag_2_o    = alloc_1_i ? w_alloc_t1 : w_alloc_t0;
  assign stall_o    = w_stall;
  assign empty_o    = (r_count == '0);
  assign num_free_o = r_count;

endmodule

// File: tb/tb_ir_free_list.sv
`timescale 1ns/1ps
module tb_ir_free_list;
  import drac_pkg::*;

  localparam int NFREE = FL_NUM_ENTRIES;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic              a1, a2, r1, r2, c1, c2, fl;
  phreg_t            rt1, rt2;
  phreg_t            tag_1, tag_2;
  logic              stall, empty;
  logic [FL_PTR_W:0] num_free;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ir_free_list dut (
    .clk_i           (clk),
    .rstn_i          (rstn),
    .alloc_1_i       (a1),
    .alloc_2_i       (a2),
    .tag_1_o         (tag_1),
    .tag_2_o         (tag_2),
    .stall_o         (stall),
    .release_1_i     (r1),
    .release_tag_1_i (rt1),
    .release_2_i     (r2),
    .release_tag_2_i (rt2),
    .commit_1_i      (c1),
    .commit_2_i      (c2),
    .flush_i         (fl),
    .empty_o         (empty),
    .num_free_o      (num_free)
  );

  typedef struct {
    logic a1, a2, r1; int t1;
    logic r2; int t2;
    logic c1, c2, fl;
    logic exp_stall; int exp_t1; int exp_t2; int exp_free; logic exp_empty;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic set_in(input logic i_a1, input logic i_a2, input logic i_r1, input int i_t1,
                        input logic i_r2, input int i_t2, input logic i_c1, input logic i_c2,
                        input logic i_fl);
    a1 = i_a1; a2 = i_a2; r1 = i_r1; rt1 = phreg_t'(i_t1);
    r2 = i_r2; rt2 = phreg_t'(i_t2); c1 = i_c1; c2 = i_c2; fl = i_fl;
  endtask

  task automatic idle();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rstn = 1'b0;
    @(negedge clk);
    chk("reset_stall", stall, 0);
    chk("reset_empty", empty, 0);
    chk("reset_free", num_free, NFREE);
    chk("reset_tag1", tag_1, FL_NUM_ARCH_REGS);
    $display("reset applied");
    @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  // Reference model: committed view of the list as a queue of tags, plus the
  // number of entries at its front that are speculatively handed out.
  int model_q[$];
  int spec_off;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[9];
    idle();

    // ---------------- table-driven vectors from reset ----------------
    tbl[0] = '{1,1,0,0,0,0,0,0,0, 0, 32, 33, 32, 0};
    tbl[1] = '{0,0,0,0,0,0,0,0,0, 0, 34, -1, 30, 0};
    tbl[2] = '{0,1,0,0,0,0,0,0,0, 0, 34, 34, 30, 0};
    tbl[3] = '{0,0,0,0,0,0,0,0,0, 0, 35, -1, 29, 0};
    tbl[4] = '{1,0,0,0,0,0,1,1,0, 0, 35, -1, 29, 0};
    tbl[5] = '{1,1,1,3,0,0,0,0,1, 0, 36, 37, 28, 0};
    tbl[6] = '{0,0,0,0,0,0,0,0,0, 0, 34, -1, 31, 0};
    tbl[7] = '{1,1,0,0,0,0,0,0,0, 0, 34, 35, 31, 0};
    tbl[8] = '{0,0,0,0,0,0,0,0,0, 0, 36, -1, 29, 0};

    do_reset();
    for (int i = 0; i < 9; i++) begin
      set_in(tbl[i].a1, tbl[i].a2, tbl[i].r1, tbl[i].t1, tbl[i].r2, tbl[i].t2,
             tbl[i].c1, tbl[i].c2, tbl[i].fl);
      @(negedge clk);
      chk($sformatf("tbl%0d_stall", i), stall, tbl[i].exp_stall);
      chk($sformatf("tbl%0d_free", i), num_free, tbl[i].exp_free);
      chk($sformatf("tbl%0d_empty", i), empty, tbl[i].exp_empty);
      if (tbl[i].exp_t1 >= 0) chk($sformatf("tbl%0d_tag1", i), tag_1, tbl[i].exp_t1);
      if (tbl[i].exp_t2 >= 0) chk($sformatf("tbl%0d_tag2", i), tag_2, tbl[i].exp_t2);
      $display("tbl %0d: tag1=%0d tag2=%0d stall=%b free=%0d", i, tag_1, tag_2, stall, num_free);
      tick();
    end
    idle();

    // ---------------- slot 2 alone is compacted onto head ----------------
    do_reset();
    set_in(0, 1, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("s2only_tag2", tag_2, 32);
    chk("s2only_stall", stall, 0);
    tick();
    idle();
    @(negedge clk);
    chk("s2only_next_tag1", tag_1, 33);
    chk("s2only_next_free", num_free, 31);
    $display("seq slot2-only: tag1=%0d free=%0d", tag_1, num_free);

    // ---------------- drain to one, stall a pair, then empty ----------------
    do_reset();
    for (int i = 0; i < 15; i++) begin
      set_in(1, 1, 0, 0, 0, 0, 0, 0, 0);
      tick();
    end
    set_in(1, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    set_in(1, 1, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("drain_free1", num_free, 1);
    chk("drain_pair_stall", stall, 1);
    chk("drain_pair_tag1", tag_1, 63);
    tick();
    set_in(1, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("drain_hold_free", num_free, 1);
    chk("drain_single_stall", stall, 0);
    chk("drain_single_tag1", tag_1, 63);
    tick();
    set_in(1, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("drain_empty", empty, 1);
    chk("drain_free0", num_free, 0);
    chk("drain_empty_stall", stall, 1);
    $display("seq drain: empty=%b free=%0d stall=%b", empty, num_free, stall);
    tick();

    // ---------------- refill from empty with wrapped pointers ----------------
    set_in(0, 0, 1, 5, 1, 7, 0, 0, 0);
    tick();
    set_in(1, 1, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("refill_free", num_free, 2);
    chk("refill_tag1", tag_1, 5);
    chk("refill_tag2", tag_2, 7);
    chk("refill_stall", stall, 0);
    tick();
    idle();
    @(negedge clk);
    chk("refill_after_free", num_free, 0);
    $display("seq refill: free=%0d empty=%b", num_free, empty);
`ifdef FREE_LIST_BYPASS_EN
    set_in(1, 0, 1, 9, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("bypass_stall", stall, 0);
    chk("bypass_tag1", tag_1, 9);
    tick();
    idle();
    @(negedge clk);
    chk("bypass_free", num_free, 0);
    $display("seq bypass: free=%0d", num_free);
`endif

    // ---------------- allocate 4, commit 2, flush ----------------
    do_reset();
    set_in(1, 1, 0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    set_in(0, 0, 0, 0, 0, 0, 1, 1, 0);
    @(negedge clk);
    chk("flush_pre_free", num_free, 28);
    tick();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 1);
    tick();
    idle();
    @(negedge clk);
    chk("flush_free", num_free, 30);
    chk("flush_tag1", tag_1, 34);
    $display("seq flush: free=%0d tag1=%0d", num_free, tag_1);

    // ---------------- randomized run against the queue model ----------------
    do_reset();
    model_q.delete();
    for (int i = 0; i < NFREE; i++) model_q.push_back(FL_NUM_ARCH_REGS + i);
    spec_off = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      int   cnt, req, cn, room, idx;
      logic ra1, ra2, rr1, rr2, rc1, rc2, rfl, exp_stall, grant;
      int   rt1v, rt2v;
      bit   alloc_heavy;
      alloc_heavy = ((cyc / 50) % 2) == 0;
      ra1 = alloc_heavy ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      ra2 = alloc_heavy ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      cnt = model_q.size() - spec_off;
      req = int'(ra1) + int'(ra2);
      cn  = $urandom_range(0, (spec_off < 2) ? spec_off : 2);
      rc1 = (cn >= 1);
      rc2 = (cn == 2);
      room = NFREE - model_q.size();
      rr1 = (room >= 1) && ($urandom_range(0, 1) == 1);
      rr2 = (room >= int'(rr1) + 1) && ($urandom_range(0, 1) == 1);
`ifdef FREE_LIST_BYPASS_EN
      if (req > cnt) begin
        rr1 = 0;
        rr2 = 0;
      end
`endif
      rt1v = $urandom_range(0, 63);
      rt2v = $urandom_range(0, 63);
      rfl  = ($urandom_range(0, 19) == 0);
      set_in(ra1, ra2, rr1, rt1v, rr2, rt2v, rc1, rc2, rfl);
      exp_stall = (req > cnt);
      @(negedge clk);
      chk("rnd_stall", stall, exp_stall);
      chk("rnd_free", num_free, cnt);
      chk("rnd_empty", empty, cnt == 0);
      if (cnt >= 1) chk("rnd_tag1", tag_1, model_q[spec_off]);
      if (ra2) begin
        idx = ra1 ? 1 : 0;
        if (idx < cnt) chk("rnd_tag2", tag_2, model_q[spec_off + idx]);
      end
      $display("rnd %0d: a=%b%b r=%b%b c=%b%b f=%b stall=%b free=%0d", cyc,
               ra1, ra2, rr1, rr2, rc1, rc2, rfl, stall, num_free);
      // Model update.
      grant = !exp_stall && !rfl;
      for (int k = 0; k < cn; k++) void'(model_q.pop_front());
      spec_off -= cn;
      if (rr1) model_q.push_back(rt1v);
      if (rr2) model_q.push_back(rt2v);
      if (rfl) spec_off = 0;
      else if (grant) spec_off += req;
      tick();
    end
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
